store_unit: RTL and testbench
=============================

# store_unit

Store-path companion to the load extender: takes a store request (func3, byte address, rs2 data) from the LSU stage and turns it into 8-byte-aligned, byte-masked write beats on the 64-bit data-memory write port. Stores that cross an 8-byte boundary are split into two beats. A one-cycle completion pulse goes back to the pipeline. Sits between the EX/LSU stage and the data-memory write interface.

## Interface
Parameters:
- none (fixed 64-bit data, 64-bit address, 8-byte lanes)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_func3  in  3  000 sb, 001 sh, 010 sw, 011 sd; 1xx illegal
- req_addr  in  64  byte address
- req_data  in  64  store data, right-justified
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  memory accepts beat
- mem_waddr  out  64  beat address, bits [2:0] always 0
- mem_wdata  out  64  lane-aligned write data
- mem_wmask  out  8  byte strobes, bit i enables wdata[8i+7:8i]
- done  out  1  one-cycle pulse when the request completes
- err  out  1  valid with done; 1 = illegal func3, no memory write
- busy  out  1  state != IDLE

## Operation
- Size n = 1, 2, 4, 8 bytes for func3 000..011. Offset off = req_addr[2:0].
- mask16 = ((1<<n)-1) << off (16 bits). data128 = {64'b0, req_data} << (8*off).
- Beat 0: addr = req_addr & ~7, mask = mask16[7:0], data = data128[63:0].
- Beat 1 (only if mask16[15:8] != 0): addr = beat-0 addr + 8 (mod 2^64), mask = mask16[15:8], data = data128[127:64].
- Bytes outside the mask carry the shifted value above, so they are deterministic but ignored by memory.
- All request fields are latched at acceptance. Inputs are don't-care afterwards.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready=1. On req_valid, latch fields. Legal func3 -> BEAT0. Illegal func3 -> RESP with err flag set.
  - BEAT0: mem_wvalid=1. On mem_wready -> BEAT1 if split, else RESP.
  - BEAT1: mem_wvalid=1. On mem_wready -> RESP.
  - RESP: done=1, err per latched flag; -> IDLE.
- While mem_wvalid=1 and mem_wready=0, mem_waddr, mem_wdata and mem_wmask hold stable.
- There is no retraction: once raised, mem_wvalid stays high until the handshake.
- Reset mid-operation: async return to IDLE. A beat already accepted is not rolled back. A pending beat is abandoned and no done is issued.

## Timing
- Reset values: req_ready=1 (state IDLE), mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wmask=0, done=0, err=0, busy=0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Accept at edge T0 (req_valid & req_ready):
  - mem_wvalid is high from T0+1.
  - Unsplit store with mem_wready=1: handshake at T0+1, done high in cycle T0+2, req_ready high again at T0+3.
  - Split store: one extra cycle per beat plus any wait cycles.
  - Illegal func3: done/err in cycle T0+1.
- Throughput: at most one request per 3 cycles (unsplit, no backpressure).
- err=0 whenever done=0.

## Structure
- Package store_pkg: func3 constants (F3_SB, F3_SH, F3_SW, F3_SD) and the state enum (IDLE, BEAT0, BEAT1, RESP). Share the func3 constants with the load path.
- Sub-module store_align: purely combinational; (func3[1:0], off, data) -> mask16, data128. Instantiated once on the latched fields.
- The top level holds the FSM, the latch registers and the beat muxing.

## Test plan
- sb, addr 0x8000_0003, data 0x...AB, mem_wready=1 -> one beat: waddr 0x8000_0000, wmask 0x08, wdata 0x0000_0000_AB00_0000; done in cycle T0+2, err=0.
- sd, addr 0x8000_0010, data 0x1122_3344_5566_7788 -> one beat: waddr 0x8000_0010, wmask 0xFF, wdata 0x1122_3344_5566_7788.
- sw, addr 0x8000_0006, data 0xDEAD_BEEF -> two beats:
  - beat 0: waddr 0x8000_0000, wmask 0xC0, wdata[63:48]=0xBEEF.
  - beat 1: waddr 0x8000_0008, wmask 0x03, wdata[15:0]=0xDEAD.
  - single done after beat 1.
- Backpressure: sh at 0x...07 with mem_wready low for 3 cycles on each beat -> waddr/wdata/wmask stable while stalled; req_ready=0 and busy=1 throughout; exactly one done.
- func3=3'b101 -> no mem_wvalid ever; done=1 and err=1 in cycle T0+1; back to IDLE.
- rst_n pulled low while waiting in BEAT1 -> all outputs at reset values immediately (asynchronous, not waiting for a clock edge); no done; after release, a new sb is accepted normally.

Source files
------------

// File: rtl/store_pkg.sv
// Shared store/load encodings: func3 size codes, store FSM states, byte-lane mask helper.
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Unshifted byte strobes for an access of 1, 2, 4 or 8 bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_align.sv
// Lane alignment for a store: shifts strobes and data to the byte offset across two 8-byte beats.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]   size,
  input  logic [2:0]   off,
  input  logic [63:0]  data,
  output logic [15:0]  mask16,
  output logic [127:0] data128
);

  always_comb begin
    mask16  = {8'h00, size_mask(size)} << off;
    data128 = {64'h0, data} << {off, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// Store request to 8-byte-aligned masked write beats; splits boundary-crossing stores into two beats.
module store_unit
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        done,
  output logic        err,
  output logic        busy
);

  state_t       state, next_state;
  logic [1:0]   size_p0;
  logic [63:0]  addr_p0;
  logic [63:0]  data_p0;
  logic         err_p0;
  logic         accept;
  logic         split;
  logic [15:0]  mask16;
  logic [127:0] data128;
  logic [63:0]  beat0_addr;
  logic [63:0]  beat1_addr;

  assign accept = req_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      err_p0 <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) err_p0 <= req_func3[2];
    end
  end

  // Request capture stage: data fields need no reset, they are only observed outside IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      size_p0 <= req_func3[1:0];
      addr_p0 <= req_addr;
      data_p0 <= req_data;
    end
  end

  store_align u_align (
    .size    (size_p0),
    .off     (addr_p0[2:0]),
    .data    (data_p0),
    .mask16  (mask16),
    .data128 (data128)
  );

  assign split      = |mask16[15:8];
  assign beat0_addr = {addr_p0[63:3], 3'b000};
  assign beat1_addr = beat0_addr + 64'd8;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = req_func3[2] ? RESP : BEAT0;
      BEAT0:   if (mem_wready) next_state = split ? BEAT1 : RESP;
      BEAT1:   if (mem_wready) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat fields are forced to zero outside a beat so reset and idle show a clean bus.
  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    mem_wvalid = 1'b0;
    mem_waddr  = 64'h0;
    mem_wdata  = 64'h0;
    mem_wmask  = 8'h00;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      BEAT0: begin
        mem_wvalid = 1'b1;
        mem_waddr  = beat0_addr;
        mem_wdata  = data128[63:0];
        mem_wmask  = mask16[7:0];
      end
      BEAT1: begin
        mem_wvalid = 1'b1;
        mem_waddr  = beat1_addr;
        mem_wdata  = data128[127:64];
        mem_wmask  = mask16[15:8];
      end
      RESP: begin
        done = 1'b1;
        err  = err_p0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: aligned, split, stalled, illegal and mid-beat reset stores.
module tb_store_unit;
  import store_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        done;
  logic        err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] a, input logic [7:0] m,
                          input logic [63:0] d);
    chk({tag, " wvalid"}, 64'(mem_wvalid), 64'd1);
    chk({tag, " waddr"},  mem_waddr, a);
    chk({tag, " wmask"},  64'(mem_wmask), 64'(m));
    chk({tag, " wdata"},  mem_wdata, d);
    chk({tag, " ready"},  64'(req_ready), 64'd0);
    chk({tag, " busy"},   64'(busy), 64'd1);
    chk({tag, " done"},   64'(done), 64'd0);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " wvalid"}, 64'(mem_wvalid), 64'd0);
    chk({tag, " waddr"},  mem_waddr, 64'h0);
    chk({tag, " wmask"},  64'(mem_wmask), 64'h0);
    chk({tag, " wdata"},  mem_wdata, 64'h0);
  endtask

  // Called at a negedge; returns at the negedge of cycle T0+1.
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_func3 = f3;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_func3 = 3'b111;
    req_addr  = '1;
    req_data  = '1;
  endtask

  task automatic chk_done(input string tag, input logic e);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " err"},  64'(err), 64'(e));
    chk({tag, " resp wvalid"}, 64'(mem_wvalid), 64'd0);
    @(negedge clk);
    chk({tag, " done drop"}, 64'(done), 64'd0);
    chk({tag, " err drop"},  64'(err), 64'd0);
    chk({tag, " ready back"}, 64'(req_ready), 64'd1);
    chk({tag, " busy drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_func3  = 3'b000;
    req_addr   = 64'h0;
    req_data   = 64'h0;
    mem_wready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst ready", 64'(req_ready), 64'd1);
    chk("rst busy",  64'(busy), 64'd0);
    chk("rst done",  64'(done), 64'd0);
    chk("rst err",   64'(err), 64'd0);
    chk_idle_bus("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // sb at offset 3
    issue(F3_SB, 64'h8000_0003, 64'h1111_2222_3333_44AB);
    chk_beat("sb", 64'h8000_0000, 8'h08, 64'h2222_3333_44AB_0000 << 8);
    @(negedge clk);
    chk_done("sb", 1'b0);

    // sd, aligned
    issue(F3_SD, 64'h8000_0010, 64'h1122_3344_5566_7788);
    chk_beat("sd", 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
    @(negedge clk);
    chk_done("sd", 1'b0);

    // sw crossing the 8-byte boundary
    issue(F3_SW, 64'h8000_0006, 64'h0000_0000_DEAD_BEEF);
    chk_beat("sw b0", 64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000);
    @(negedge clk);
    chk_beat("sw b1", 64'h8000_0008, 8'h03, 64'h0000_0000_0000_DEAD);
    @(negedge clk);
    chk_done("sw", 1'b0);

    // sh at offset 7 with three stall cycles on each beat
    mem_wready = 1'b0;
    issue(F3_SH, 64'h8000_0007, 64'hAAAA_AAAA_AAAA_1234);
    for (int i = 0; i < 3; i++) begin
      chk_beat("sh stall b0", 64'h8000_0000, 8'h80, 64'h3400_0000_0000_0000);
      @(negedge clk);
    end
    mem_wready = 1'b1;
    chk_beat("sh b0", 64'h8000_0000, 8'h80, 64'h3400_0000_0000_0000);
    @(negedge clk);
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_beat("sh stall b1", 64'h8000_0008, 8'h01, 64'h00AA_AAAA_AAAA_AA12);
      @(negedge clk);
    end
    mem_wready = 1'b1;
    chk_beat("sh b1", 64'h8000_0008, 8'h01, 64'h00AA_AAAA_AAAA_AA12);
    @(negedge clk);
    chk_done("sh", 1'b0);

    // illegal func3
    issue(3'b101, 64'h8000_0020, 64'h5555_5555_5555_5555);
    chk_idle_bus("ill");
    chk_done("ill", 1'b1);

    // reset asserted while waiting on beat 1
    issue(F3_SW, 64'h8000_0006, 64'h0000_0000_CAFE_F00D);
    chk_beat("rs b0", 64'h8000_0000, 8'hC0, 64'hF00D_0000_0000_0000);
    @(negedge clk);
    mem_wready = 1'b0;
    chk_beat("rs b1", 64'h8000_0008, 8'h03, 64'h0000_0000_0000_CAFE);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ready", 64'(req_ready), 64'd1);
    chk("async rst busy",  64'(busy), 64'd0);
    chk("async rst done",  64'(done), 64'd0);
    chk("async rst err",   64'(err), 64'd0);
    chk_idle_bus("async rst");
    mem_wready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst done", 64'(done), 64'd0);
    chk("post rst ready", 64'(req_ready), 64'd1);

    // normal sb after reset release
    issue(F3_SB, 64'h8000_0105, 64'h0000_0000_0000_005A);
    chk_beat("sb2", 64'h8000_0100, 8'h20, 64'h0000_5A00_0000_0000);
    @(negedge clk);
    chk_done("sb2", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
